// File: rtl/i2c_pkg.sv
// Shared I2C types and constants for the receive/transmit datapaths.
package i2c_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ACK   = 2'd2,
    ST_DONE  = 2'd3
  } stp_state_t;

  // Value of sda_drive_low during the master ACK slot.
  localparam logic ACK  = 1'b1;
  localparam logic NACK = 1'b0;

endpackage

// File: rtl/i2c_stp_receiver.sv
// Serial-to-parallel receiver for the I2C master read path: samples SDA on
// SCL-rise strobes, assembles NUM_BYTES bytes (MSB first) and drives ACK/NACK.
module i2c_stp_receiver
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 2,
  localparam int unsigned DATA_W = BYTE_W * NUM_BYTES,
  localparam int unsigned CYC_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stp_start,
  input  logic                 stp_abort,
  input  logic                 sample_tick,
  input  logic                 sda_in,
  output logic                 busy,
  output logic [CYC_W-1:0]     cycle_out,
  output logic [BIT_CNT_W-1:0] counter_out,
  output logic                 sda_drive_low,
  output logic [DATA_W-1:0]    data_out,
  output logic                 data_valid
);

  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(NUM_BYTES - 1);

  stp_state_t                  state_q, state_n;
  logic [CYC_W-1:0]            cycle_q, cycle_n;
  logic [BIT_CNT_W-1:0]        counter_q, counter_n;
  logic [DATA_W-1:0]           shreg_q, shreg_n;
  logic [DATA_W-1:0]           data_q, data_n;
  logic                        busy_n, valid_n, drive_n;
  logic [CYC_W+BIT_CNT_W-1:0]  bit_idx;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cycle_q       <= '0;
      counter_q     <= '0;
      shreg_q       <= '0;
      data_q        <= '0;
      busy          <= 1'b0;
      data_valid    <= 1'b0;
      sda_drive_low <= 1'b0;
    end else begin
      state_q       <= state_n;
      cycle_q       <= cycle_n;
      counter_q     <= counter_n;
      shreg_q       <= shreg_n;
      data_q        <= data_n;
      busy          <= busy_n;
      data_valid    <= valid_n;
      sda_drive_low <= drive_n;
    end
  end

  // Next-state, bit placement and output decode.
  always_comb begin
    state_n   = state_q;
    cycle_n   = cycle_q;
    counter_n = counter_q;
    shreg_n   = shreg_q;
    data_n    = data_q;
    // cycle*8 + (7-counter): byte lane from cycle, MSB-first bit from counter.
    bit_idx   = {cycle_q, ~counter_q};

    unique case (state_q)
      ST_IDLE: begin
        if (stp_start && !stp_abort) begin
          state_n   = ST_SHIFT;
          cycle_n   = '0;
          counter_n = '0;
          shreg_n   = '0;
        end
      end
      ST_SHIFT: begin
        if (stp_abort) begin
          state_n = ST_IDLE;
        end else if (sample_tick) begin
          shreg_n[bit_idx] = sda_in;
          counter_n        = counter_q + BIT_CNT_W'(1);
          if (counter_q == BIT_CNT_W'(BYTE_W - 1)) begin
            state_n = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (stp_abort) begin
          state_n = ST_IDLE;
        end else if (sample_tick) begin
          if (cycle_q == LAST_CYC) begin
            state_n = ST_DONE;
            data_n  = shreg_q;
          end else begin
            state_n = ST_SHIFT;
            cycle_n = cycle_q + CYC_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n  = (state_n != ST_IDLE);
    valid_n = (state_n == ST_DONE);
    drive_n = (state_n == ST_ACK) ? ((cycle_n == LAST_CYC) ? NACK : ACK) : 1'b0;
  end

  assign cycle_out   = cycle_q;
  assign counter_out = counter_q;
  assign data_out    = data_q;

endmodule

// File: tb/tb_i2c_stp_receiver.sv
// Scoreboard bench for i2c_stp_receiver: driver pushes expected words, monitor
// pops and compares on every data_valid pulse.
module tb_i2c_stp_receiver;

  localparam int NB = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stp_start = 1'b0;
  logic        stp_abort = 1'b0;
  logic        sample_tick = 1'b0;
  logic        sda_in = 1'b0;
  logic        busy;
  logic [0:0]  cycle_out;
  logic [2:0]  counter_out;
  logic        sda_drive_low;
  logic [15:0] data_out;
  logic        data_valid;

  i2c_stp_receiver #(.NUM_BYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .stp_start(stp_start), .stp_abort(stp_abort),
    .sample_tick(sample_tick), .sda_in(sda_in), .busy(busy),
    .cycle_out(cycle_out), .counter_out(counter_out),
    .sda_drive_low(sda_drive_low), .data_out(data_out), .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_data = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && data_valid) begin
      check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("word", 32'(data_out), 32'(exp_q.pop_front()));
    end
  end

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic tick(input logic sda);
    sample_tick = 1'b1;
    sda_in = sda;
    @(negedge clk);
    sample_tick = 1'b0;
    sda_in = 1'($urandom);
  endtask

  // mode: 0 complete word, 1 abort, 2 reset, after stop_at ticks (data+ack).
  task automatic send_word(input logic [15:0] w, input int mode, input int stop_at,
                           input bit tick_on_start, input bit noise);
    int t = 0;
    stp_start = 1'b1;
    sample_tick = tick_on_start;
    sda_in = ~w[7];
    @(negedge clk);
    stp_start = 1'b0;
    sample_tick = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int b = 0; b < NB; b++) begin
      for (int i = 7; i >= -1; i--) begin
        gap();
        if (mode != 0 && t == stop_at) begin
          if (mode == 1) begin
            stp_abort = 1'b1;
            @(negedge clk);
            stp_abort = 1'b0;
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_drive", 32'(sda_drive_low), 32'd0);
            check("abort_data_held", 32'(data_out), 32'(model_data));
          end else begin
            #2 rst_n = 1'b0;
            model_data = 16'h0;
            #1;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_drive", 32'(sda_drive_low), 32'd0);
            check("rst_data", 32'(data_out), 32'd0);
            check("rst_valid", 32'(data_valid), 32'd0);
            check("rst_idx", 32'({cycle_out, counter_out}), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
          end
          return;
        end
        if (i >= 0) begin
          if (noise && b == NB - 1 && i == 4) begin
            stp_start = 1'b1;
            @(negedge clk);
            stp_start = 1'b0;
          end
          check("counter", 32'(counter_out), 32'(7 - i));
          check("cycle", 32'(cycle_out), 32'(b));
          tick(w[8*b + i]);
        end else begin
          check("ack_slot", 32'(sda_drive_low), (b < NB - 1) ? 32'd1 : 32'd0);
          check("ack_busy", 32'(busy), 32'd1);
          if (b == NB - 1) begin
            exp_q.push_back(w);
            model_data = w;
          end
          tick(1'($urandom));
          if (b == NB - 1) begin
            check("valid_latency", 32'(data_valid), 32'd1);
            @(negedge clk);
            check("idle_after_done", 32'(busy), 32'd0);
            check("valid_single", 32'(data_valid), 32'd0);
          end
        end
        t++;
      end
    end
  endtask

  task automatic idle_ticks(input int n);
    repeat (n) begin
      tick(1'($urandom));
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_data", 32'(data_out), 32'(model_data));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", 32'({busy, cycle_out, counter_out, sda_drive_low, data_valid}), 32'd0);
    check("reset_data", 32'(data_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send_word(16'h3CA5, 0, 0, 1'b0, 1'b0);
    check("word1_held", 32'(data_out), 32'h3CA5);
    send_word(16'h0000, 1, 5, 1'b0, 1'b0);
    check("abort_keeps", 32'(data_out), 32'h3CA5);
    send_word(16'h5555, 2, 9, 1'b0, 1'b0);
    send_word(16'h00FF, 0, 0, 1'b0, 1'b0);
    check("after_reset_word", 32'(data_out), 32'h00FF);
    send_word(16'h6A9C, 0, 0, 1'b0, 1'b1);
    idle_ticks(5);
    check("idle_counter", 32'(counter_out), 32'd0);
    check("idle_cycle", 32'(cycle_out), 32'(NB - 1));
    send_word(16'h1234, 0, 0, 1'b0, 1'b0);
    send_word(16'hBEEF, 0, 0, 1'b0, 1'b0);

    stp_start = 1'b1;
    stp_abort = 1'b1;
    @(negedge clk);
    stp_start = 1'b0;
    stp_abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    idle_ticks(3);
    send_word(16'hC3E1, 0, 0, 1'b1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      int r = int'($urandom_range(0, 9));
      int mode = (r < 6) ? 0 : (r < 9) ? 1 : 2;
      send_word(16'($urandom), mode, int'($urandom_range(0, 17)), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle_ticks(2);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
